// File: rtl/crono_pkg.sv
// Shared types and constants for the crono countdown timer.
// Holds the FSM encoding, the BCD field limits and the capture sanitiser.
package crono_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } crono_state_e;

  localparam logic [7:0] BCD_MAX_MS       = 8'h59;
  localparam logic [7:0] BCD_MAX_H        = 8'h23;
  localparam int         TICK_DIV_DEFAULT = 100000000;

  // Nibbles above 9 become 9; because both nibbles are then valid BCD,
  // a plain magnitude compare against the field limit does the clamp.
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] t;
    t[7:4] = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    t[3:0] = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return (t > lim) ? lim : t;
  endfunction

endpackage

// File: rtl/crono_countdown_if.sv
// Command and display bundle of the countdown timer.
// master = user logic issuing commands, slave = the timer.
interface crono_countdown_if;
  logic       load;
  logic       start;
  logic       stop;
  logic [7:0] hh_in;
  logic [7:0] mm_in;
  logic [7:0] ss_in;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       running;
  logic       irq;

  modport master (
    output load, start, stop, hh_in, mm_in, ss_in,
    input  hh, mm, ss, running, irq
  );

  modport slave (
    input  load, start, stop, hh_in, mm_in, ss_in,
    output hh, mm, ss, running, irq
  );
endinterface

// File: rtl/bcd_down2.sv
// Two-digit BCD down-counter with synchronous load, wrapping 00 -> max_val.
// Latency: value updates 1 clk after load/dec_en; borrow_out is combinational.
// Backpressure: none, load has priority over dec_en.
module bcd_down2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_en,
  input  logic [7:0] max_val,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       borrow_out
);

  assign borrow_out = dec_en && (value == 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_val;
    end else if (dec_en) begin
      if (value == 8'h00)
        value <= max_val;
      else if (value[3:0] == 4'd0)
        value <= {value[7:4] - 4'd1, 4'd9};
      else
        value <= {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/crono_countdown.sv
// BCD hh:mm:ss countdown timer with one-clk expiry irq; CRONO_AUTORELOAD_EN enables periodic reload.
// Latency: load->count 1 clk, start->running 1 clk, final tick->irq 1 clk.
// Backpressure: none; commands are levels sampled every clk, stop beats start, load beats start.
module crono_countdown
  import crono_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int TICK_W   = 27
) (
  input  logic               clk,
  input  logic               reset,
  crono_countdown_if.slave   bus
);

  localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(TICK_DIV - 1);

  crono_state_e      state, state_nxt;
  logic [TICK_W-1:0] presc, presc_nxt;
  logic              tick;
  logic              cap;
  logic              ld;
  logic [23:0]       ld_val;
  logic [23:0]       cap_val;
  logic [7:0]        hh_q, mm_q, ss_q;
  logic              ss_borrow, mm_borrow, hh_borrow_unused;
  logic              count_zero, count_one;

  assign cap_val    = {bcd_sanitize(bus.hh_in, BCD_MAX_H),
                       bcd_sanitize(bus.mm_in, BCD_MAX_MS),
                       bcd_sanitize(bus.ss_in, BCD_MAX_MS)};
  assign count_zero = ({hh_q, mm_q, ss_q} == 24'h000000);
  assign count_one  = ({hh_q, mm_q, ss_q} == 24'h000001);

`ifdef CRONO_AUTORELOAD_EN
  logic [23:0] reload_q;
  logic        reload_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      reload_q <= 24'h000000;
    else if (cap)
      reload_q <= cap_val;
  end

  assign ld     = cap | reload_now;
  assign ld_val = cap ? cap_val : reload_q;
`else
  assign ld     = cap;
  assign ld_val = cap_val;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      presc <= '0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    tick      = 1'b0;
    cap       = 1'b0;
`ifdef CRONO_AUTORELOAD_EN
    reload_now = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.load) begin
          cap = 1'b1;
        end else if (bus.start && !bus.stop && !count_zero) begin
          state_nxt = ST_RUN;
          presc_nxt = '0;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_nxt = ST_PAUSE;
        end else if (presc == PRESC_MAX) begin
          tick      = 1'b1;
          presc_nxt = '0;
          if (count_one)
            state_nxt = ST_DONE;
        end else begin
          presc_nxt = presc + TICK_W'(1);
        end
      end
      ST_PAUSE: begin
        if (bus.load) begin
          cap       = 1'b1;
          presc_nxt = '0;
        end else if (bus.start && !bus.stop && !count_zero) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
`ifdef CRONO_AUTORELOAD_EN
        // Prescaler wrapped to 0 on the final tick; the DONE cycle is the
        // first cycle of the next period so irq stays exactly periodic.
        if (reload_q != 24'h000000) begin
          state_nxt  = ST_RUN;
          reload_now = 1'b1;
          presc_nxt  = presc + TICK_W'(1);
        end else begin
          state_nxt = ST_IDLE;
          presc_nxt = '0;
        end
`else
        state_nxt = ST_IDLE;
        presc_nxt = '0;
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
        presc_nxt = '0;
      end
    endcase
  end

  bcd_down2 u_ss (
    .clk(clk), .reset(reset), .dec_en(tick), .max_val(BCD_MAX_MS),
    .load(ld), .load_val(ld_val[7:0]), .value(ss_q), .borrow_out(ss_borrow)
  );

  bcd_down2 u_mm (
    .clk(clk), .reset(reset), .dec_en(ss_borrow), .max_val(BCD_MAX_MS),
    .load(ld), .load_val(ld_val[15:8]), .value(mm_q), .borrow_out(mm_borrow)
  );

  bcd_down2 u_hh (
    .clk(clk), .reset(reset), .dec_en(mm_borrow), .max_val(BCD_MAX_H),
    .load(ld), .load_val(ld_val[23:16]), .value(hh_q), .borrow_out(hh_borrow_unused)
  );

  assign bus.hh      = hh_q;
  assign bus.mm      = mm_q;
  assign bus.ss      = ss_q;
  assign bus.running = (state == ST_RUN);
  assign bus.irq     = (state == ST_DONE);

endmodule

// File: tb/tb_crono_countdown.sv
// Directed bench for crono_countdown at TICK_DIV=4: vector table plus multi-cycle sequences.
module tb_crono_countdown;

`ifdef CRONO_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crono_countdown_if bus ();

  crono_countdown #(.TICK_DIV(4), .TICK_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int irq_cnt = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.irq === 1'b1) irq_cnt++;

  typedef struct {
    logic       ld, st, sp;
    logic [7:0] hi, mi, si;
    logic [7:0] eh, em, es;
    logic       er, ei;
  } vec_t;

  vec_t tv[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic l, input logic s, input logic p,
                     input logic [7:0] h, input logic [7:0] m, input logic [7:0] sv);
    bus.load  = l;
    bus.start = s;
    bus.stop  = p;
    bus.hh_in = h;
    bus.mm_in = m;
    bus.ss_in = sv;
  endtask

  task automatic reset_dut();
    drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic setv(input int i, input logic l, input logic s, input logic p,
                      input logic [7:0] h, input logic [7:0] m, input logic [7:0] sv,
                      input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                      input logic er, input logic ei);
    tv[i] = '{l, s, p, h, m, sv, eh, em, es, er, ei};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int base;
    bit got;
    logic [7:0] ar_ss;
    logic       ar_run;

    ar_ss  = AR ? 8'h02 : 8'h00;
    ar_run = AR;

    //      ld st sp  hh_in  mm_in  ss_in    hh     mm     ss   run irq
    setv( 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    setv( 1, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    setv( 2, 1, 0, 0, 8'h4A, 8'h7F, 8'h99, 8'h23, 8'h59, 8'h59, 0, 0);
    setv( 3, 1, 0, 0, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 0, 0);
    setv( 4, 1, 0, 0, 8'h0A, 8'h5A, 8'h60, 8'h09, 8'h59, 8'h59, 0, 0);
    setv( 5, 1, 1, 0, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h07, 0, 0);
    setv( 6, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 0, 0);
    setv( 7, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 0, 0);
    setv( 8, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 1, 0);
    setv( 9, 1, 0, 0, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00, 8'h07, 1, 0);
    setv(10, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 0, 0);
    setv(11, 1, 0, 0, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 0, 0);
    setv(12, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0);
    setv(13, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0);
    setv(14, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0);
    setv(15, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0);
    setv(16, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0);
    setv(17, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0);
    setv(18, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0);
    setv(19, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0);
    setv(20, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
    setv(21, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, ar_ss, ar_run, 0);
    setv(22, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, ar_ss, ar_run, 0);
    setv(23, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, ar_ss, 0, 0);

    drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    step(2);
    chk("reset hh:mm:ss", {bus.hh, bus.mm, bus.ss}, 24'h000000);
    chk("reset running", bus.running, 1'b0);
    chk("reset irq", bus.irq, 1'b0);
    reset = 1'b0;
    step(1);

    for (int i = 0; i < 24; i++) begin
      drv(tv[i].ld, tv[i].st, tv[i].sp, tv[i].hi, tv[i].mi, tv[i].si);
      step(1);
      chk($sformatf("vec%0d hh", i), bus.hh, tv[i].eh);
      chk($sformatf("vec%0d mm", i), bus.mm, tv[i].em);
      chk($sformatf("vec%0d ss", i), bus.ss, tv[i].es);
      chk($sformatf("vec%0d running", i), bus.running, tv[i].er);
      chk($sformatf("vec%0d irq", i), bus.irq, tv[i].ei);
    end

    // Countdown from 3: irq 12 clk after the start edge
    reset_dut();
    base = irq_cnt;
    drv(1, 0, 0, 8'h00, 8'h00, 8'h03); step(1);
    drv(0, 1, 0, 8'h00, 8'h00, 8'h00); step(1);
    chk("A running", bus.running, 1'b1);
    drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
    k = 0; got = 0;
    while (k < 40 && !got) begin
      step(1);
      k++;
      if (k == 4) chk("A ss after tick1", bus.ss, 8'h02);
      if (k == 8) chk("A ss after tick2", bus.ss, 8'h01);
      if (bus.irq === 1'b1) got = 1;
    end
    chk("A irq latency", k, 12);
    chk("A ss at expiry", bus.ss, 8'h00);
    step(1);
    chk("A irq width", bus.irq, 1'b0);
    chk("A irq count", irq_cnt - base, 1);
    chk("A running after", bus.running, ar_run);
    drv(0, 0, 1, 8'h00, 8'h00, 8'h00); step(2);

    // Cascaded borrow from 01:00:00
    reset_dut();
    drv(1, 0, 0, 8'h01, 8'h00, 8'h00); step(1);
    drv(0, 1, 0, 8'h00, 8'h00, 8'h00); step(1);
    drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(4);
    chk("B borrow tick1", {bus.hh, bus.mm, bus.ss}, 24'h005959);
    step(4);
    chk("B borrow tick2", {bus.hh, bus.mm, bus.ss}, 24'h005958);
    drv(0, 0, 1, 8'h00, 8'h00, 8'h00); step(1);

    // Pause for 20 clk then resume
    reset_dut();
    drv(1, 0, 0, 8'h00, 8'h00, 8'h05); step(1);
    drv(0, 1, 0, 8'h00, 8'h00, 8'h00); step(1);
    drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(8);
    chk("C ss before pause", bus.ss, 8'h03);
    base = irq_cnt;
    drv(0, 0, 1, 8'h00, 8'h00, 8'h00);
    step(20);
    chk("C ss frozen", bus.ss, 8'h03);
    chk("C running paused", bus.running, 1'b0);
    chk("C no irq in pause", irq_cnt - base, 0);
    drv(0, 1, 0, 8'h00, 8'h00, 8'h00); step(1);
    chk("C resumed", bus.running, 1'b1);
    drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
    k = 0; got = 0;
    while (k < 40 && !got) begin
      step(1);
      k++;
      if (bus.irq === 1'b1) got = 1;
    end
    chk("C resume to irq", k, 12);
    step(1);
    chk("C irq count", irq_cnt - base, 1);
    drv(0, 0, 1, 8'h00, 8'h00, 8'h00); step(2);

    // Reset mid-RUN at 00:00:01
    reset_dut();
    drv(1, 0, 0, 8'h00, 8'h00, 8'h01); step(1);
    drv(0, 1, 0, 8'h00, 8'h00, 8'h00); step(1);
    drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(1);
    chk("D running before reset", bus.running, 1'b1);
    base = irq_cnt;
    #2 reset = 1'b1;
    #1;
    chk("D count on reset", {bus.hh, bus.mm, bus.ss}, 24'h000000);
    chk("D running on reset", bus.running, 1'b0);
    step(3);
    reset = 1'b0;
    step(10);
    chk("D no irq", irq_cnt - base, 0);
    chk("D idle after reset", bus.running, 1'b0);

`ifdef CRONO_AUTORELOAD_EN
    begin
      int t[3];
      int n;
      reset_dut();
      base = irq_cnt;
      drv(1, 0, 0, 8'h00, 8'h00, 8'h02); step(1);
      drv(0, 1, 0, 8'h00, 8'h00, 8'h00); step(1);
      drv(0, 0, 0, 8'h00, 8'h00, 8'h00);
      n = 0; k = 0;
      while (k < 60 && n < 3) begin
        step(1);
        k++;
        if (bus.irq === 1'b1) begin
          t[n] = cyc;
          n++;
        end
      end
      chk("E irq pulses", n, 3);
      chk("E period 1", t[1] - t[0], 8);
      chk("E period 2", t[2] - t[1], 8);
      drv(0, 0, 1, 8'h00, 8'h00, 8'h00); step(2);
      base = irq_cnt;
      step(20);
      chk("E stopped no irq", irq_cnt - base, 0);
      chk("E stopped running", bus.running, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
